// File: rtl/servant_ram_loader.sv
// servant_ram_loader
// Boot-time loader: packs a valid/ready byte stream little-endian into 32-bit
// words and writes them through the RAM's processor-side Wishbone port at
// ascending word addresses starting from BASE_ADR. Idle once the image is in.
module servant_ram_loader #(
   parameter int unsigned depth    = 256,
   parameter int unsigned aw       = $clog2(depth),
   parameter int unsigned BASE_ADR = 0
) (
   input  logic          i_wb_clk,
   input  logic          i_wb_rst_n,
   input  logic          i_start,
   input  logic          i_flush,
   input  logic [7:0]    i_byte,
   input  logic          i_byte_valid,
   output logic          o_byte_ready,
   output logic [31:0]   o_wb_proc_adr,
   output logic [31:0]   o_wb_proc_dat,
   output logic [3:0]    o_wb_proc_sel,
   output logic          o_wb_proc_we,
   output logic          o_wb_proc_stb,
   input  logic          i_wb_proc_ack,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_overflow,
   output logic [aw-2:0] o_words
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_WRITE   = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   localparam logic [aw-1:0] BASE_W  = aw'(BASE_ADR);
   localparam logic [aw:0]   DEPTH_W = (aw+1)'(depth);

   logic [1:0]    state_q, state_d;
   logic [aw-1:0] adr_q, adr_d;
   logic [31:0]   dat_q, dat_d;
   logic [3:0]    sel_q, sel_d;
   logic [1:0]    lane_q, lane_d;
   logic [aw-2:0] words_q, words_d;
   logic          flush_pend_q, flush_pend_d;
   logic          stb_q, stb_d;
   logic          ready_q, ready_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          overflow_q, overflow_d;

   logic          byte_xfer_s;
   logic          write_ack_s;
   logic          at_end_s;

   // ready is only ever high in COLLECT, where every offered byte is taken
   assign byte_xfer_s = i_byte_valid & ready_q;
   assign write_ack_s = stb_q & i_wb_proc_ack;
   // one-bit-wider sum so that reaching depth is visible even though adr wraps
   assign at_end_s    = (({1'b0, adr_q} + (aw+1)'(4)) == DEPTH_W);

   // Next-state logic: packing, write handshake and load sequencing
   always_comb begin
      state_d      = state_q;
      adr_d        = adr_q;
      dat_d        = dat_q;
      sel_d        = sel_q;
      lane_d       = lane_q;
      words_d      = words_q;
      flush_pend_d = flush_pend_q;
      overflow_d   = overflow_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               state_d      = S_COLLECT;
               adr_d        = BASE_W;
               dat_d        = 32'h0000_0000;
               sel_d        = 4'b0000;
               lane_d       = 2'd0;
               words_d      = '0;
               flush_pend_d = 1'b0;
               overflow_d   = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         S_COLLECT: begin
            if (byte_xfer_s) begin
               dat_d[{lane_q, 3'b000} +: 8] = i_byte;
               sel_d[lane_q]                = 1'b1;
               lane_d                       = lane_q + 2'd1;
               if ((lane_q == 2'd3) || i_flush) begin
                  state_d      = S_WRITE;
                  flush_pend_d = i_flush;
               end else begin
                  state_d = S_COLLECT;
               end
            end else if (i_flush) begin
               if (lane_q == 2'd0) begin
                  state_d = S_DONE;
               end else begin
                  // unused lanes are already zero: dat is cleared per word
                  state_d      = S_WRITE;
                  flush_pend_d = 1'b1;
               end
            end else begin
               state_d = S_COLLECT;
            end
         end
         S_WRITE: begin
            if (write_ack_s) begin
               adr_d   = adr_q + aw'(4);
               words_d = words_q + (aw-1)'(1);
               lane_d  = 2'd0;
               sel_d   = 4'b0000;
               dat_d   = 32'h0000_0000;
               if (at_end_s) begin
                  overflow_d   = 1'b1;
                  flush_pend_d = 1'b0;
                  state_d      = S_DONE;
               end else if (flush_pend_q) begin
                  flush_pend_d = 1'b0;
                  state_d      = S_DONE;
               end else begin
                  state_d = S_COLLECT;
               end
            end else begin
               state_d = S_WRITE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output flags follow the upcoming state so they are registered yet cycle-exact
   always_comb begin
      stb_d   = (state_d == S_WRITE);
      ready_d = (state_d == S_COLLECT);
      busy_d  = (state_d == S_COLLECT) || (state_d == S_WRITE);
      done_d  = (state_d == S_DONE);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge i_wb_clk) begin
      if (!i_wb_rst_n) begin
         state_q      <= S_IDLE;
         adr_q        <= BASE_W;
         dat_q        <= 32'h0000_0000;
         sel_q        <= 4'b0000;
         lane_q       <= 2'd0;
         words_q      <= '0;
         flush_pend_q <= 1'b0;
         stb_q        <= 1'b0;
         ready_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         adr_q        <= adr_d;
         dat_q        <= dat_d;
         sel_q        <= sel_d;
         lane_q       <= lane_d;
         words_q      <= words_d;
         flush_pend_q <= flush_pend_d;
         stb_q        <= stb_d;
         ready_q      <= ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         overflow_q   <= overflow_d;
      end
   end

   assign o_byte_ready  = ready_q;
   assign o_wb_proc_adr = {{(32-aw){1'b0}}, adr_q};
   assign o_wb_proc_dat = dat_q;
   assign o_wb_proc_sel = sel_q;
   assign o_wb_proc_we  = stb_q;
   assign o_wb_proc_stb = stb_q;
   assign o_busy        = busy_q;
   assign o_done        = done_q;
   assign o_overflow    = overflow_q;
   assign o_words       = words_q;

endmodule

// File: tb/tb_servant_ram_loader.sv
// Testbench for servant_ram_loader: transaction-level model (byte queue per
// word, word counter) checked every cycle, plus literal write expectations.
module tb_servant_ram_loader;

   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int BASE  = 0;

   localparam int P_IDLE = 0;
   localparam int P_LOAD = 1;
   localparam int P_WR   = 2;
   localparam int P_DONE = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          flush = 1'b0;
   logic [7:0]    bdat = 8'h00;
   logic          bval = 1'b0;
   logic          ack = 1'b0;
   logic          o_byte_ready;
   logic [31:0]   o_wb_proc_adr;
   logic [31:0]   o_wb_proc_dat;
   logic [3:0]    o_wb_proc_sel;
   logic          o_wb_proc_we;
   logic          o_wb_proc_stb;
   logic          o_busy;
   logic          o_done;
   logic          o_overflow;
   logic [AW-2:0] o_words;

   int errors = 0;
   int checks = 0;
   int stall_cfg = 0;
   int stall_cnt = 0;

   // behavioural model
   int       m_phase = P_IDLE;
   bit [7:0] m_bytes[$];
   int       m_words = 0;
   bit       m_fp = 1'b0;
   bit       m_ovf = 1'b0;

   logic [67:0] wlog[$];

   servant_ram_loader #(.depth(DEPTH), .aw(AW), .BASE_ADR(BASE)) dut (
      .i_wb_clk      (clk),
      .i_wb_rst_n    (rst_n),
      .i_start       (start),
      .i_flush       (flush),
      .i_byte        (bdat),
      .i_byte_valid  (bval),
      .o_byte_ready  (o_byte_ready),
      .o_wb_proc_adr (o_wb_proc_adr),
      .o_wb_proc_dat (o_wb_proc_dat),
      .o_wb_proc_sel (o_wb_proc_sel),
      .o_wb_proc_we  (o_wb_proc_we),
      .o_wb_proc_stb (o_wb_proc_stb),
      .i_wb_proc_ack (ack),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_overflow    (o_overflow),
      .o_words       (o_words)
   );

   always #5 clk = ~clk;

   // model update on every active edge from the same inputs the DUT sees
   always @(posedge clk) begin
      if (!rst_n) begin
         m_phase = P_IDLE;
         m_bytes.delete();
         m_words = 0;
         m_fp = 1'b0;
         m_ovf = 1'b0;
      end else begin
         case (m_phase)
            P_IDLE, P_DONE: begin
               if (start) begin
                  m_phase = P_LOAD;
                  m_bytes.delete();
                  m_words = 0;
                  m_fp = 1'b0;
                  m_ovf = 1'b0;
               end
            end
            P_LOAD: begin
               if (bval) begin
                  m_bytes.push_back(bdat);
                  if (m_bytes.size() == 4 || flush) begin
                     m_phase = P_WR;
                     m_fp = flush;
                  end
               end else if (flush) begin
                  if (m_bytes.size() == 0) m_phase = P_DONE;
                  else begin
                     m_phase = P_WR;
                     m_fp = 1'b1;
                  end
               end
            end
            default: begin
               if (ack) begin
                  m_words++;
                  m_bytes.delete();
                  if (BASE + 4 * m_words == DEPTH) begin
                     m_ovf = 1'b1;
                     m_fp = 1'b0;
                     m_phase = P_DONE;
                  end else if (m_fp) begin
                     m_fp = 1'b0;
                     m_phase = P_DONE;
                  end else begin
                     m_phase = P_LOAD;
                  end
               end
            end
         endcase
      end
   end

   // log of completed RAM writes as seen on the bus
   always @(posedge clk) begin
      if (rst_n && o_wb_proc_stb && ack)
         wlog.push_back({o_wb_proc_adr, o_wb_proc_dat, o_wb_proc_sel});
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_dat();
      logic [31:0] d = 32'h0;
      for (int i = 0; i < m_bytes.size(); i++) d[8*i +: 8] = m_bytes[i];
      return d;
   endfunction

   task automatic compare();
      int sz = m_bytes.size();
      chk("ready", {31'b0, o_byte_ready}, {31'b0, m_phase == P_LOAD});
      chk("stb", {31'b0, o_wb_proc_stb}, {31'b0, m_phase == P_WR});
      chk("we", {31'b0, o_wb_proc_we}, {31'b0, m_phase == P_WR});
      chk("busy", {31'b0, o_busy}, {31'b0, m_phase == P_LOAD || m_phase == P_WR});
      chk("done", {31'b0, o_done}, {31'b0, m_phase == P_DONE});
      chk("overflow", {31'b0, o_overflow}, {31'b0, m_ovf});
      chk("words", {29'b0, o_words}, 32'(m_words % 8));
      chk("adr", o_wb_proc_adr, 32'((BASE + 4 * m_words) % DEPTH));
      chk("dat", o_wb_proc_dat, model_dat());
      chk("sel", {28'b0, o_wb_proc_sel}, 32'((1 << sz) - 1));
   endtask

   // one cycle: compare at the falling edge, then drive the RAM acknowledge
   task automatic tick();
      @(negedge clk);
      compare();
      if (o_wb_proc_stb) begin
         if (stall_cnt == 0) ack = 1'b1;
         else begin
            stall_cnt--;
            ack = 1'b0;
         end
      end else begin
         ack = 1'b0;
         stall_cnt = stall_cfg;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic fl, input int maxw, output bit acc);
      bdat = b;
      bval = 1'b1;
      flush = fl;
      acc = 1'b0;
      for (int k = 0; k < maxw; k++) begin
         if (o_byte_ready) begin
            tick();
            acc = 1'b1;
            break;
         end
         tick();
      end
      bval = 1'b0;
      flush = 1'b0;
   endtask

   task automatic send_must(input logic [7:0] b, input logic fl);
      bit acc;
      send_byte(b, fl, 50, acc);
      chk("byte_accept", {31'b0, acc}, 32'd1);
   endtask

   task automatic do_flush();
      for (int k = 0; k < 50 && !o_byte_ready; k++) tick();
      chk("flush_ready", {31'b0, o_byte_ready}, 32'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 100 && !o_done; k++) tick();
      chk("wait_done", {31'b0, o_done}, 32'd1);
   endtask

   task automatic chk_wr(input int i, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      if (i < wlog.size()) begin
         chk("wr_adr", wlog[i][67:36], adr);
         chk("wr_dat", wlog[i][35:4], dat);
         chk("wr_sel", {28'b0, wlog[i][3:0]}, {28'b0, sel});
      end
   endtask

   initial begin
      bit acc;
      int nacc;
      logic [31:0] hold_dat;

      // reset
      tick();
      tick();
      chk("rst_adr", o_wb_proc_adr, 32'h0);
      chk("rst_busy", {31'b0, o_busy}, 32'd0);
      rst_n = 1'b1;
      tick();

      // two full words then flush
      wlog.delete();
      pulse_start();
      for (int i = 1; i <= 8; i++) send_must(8'(i), 1'b0);
      do_flush();
      wait_done();
      chk("t1_nwr", 32'(wlog.size()), 32'd2);
      chk_wr(0, 32'h0, 32'h0403_0201, 4'hF);
      chk_wr(1, 32'h4, 32'h0807_0605, 4'hF);
      chk("t1_words", {29'b0, o_words}, 32'd2);

      // partial word then flush
      wlog.delete();
      pulse_start();
      send_must(8'hAA, 1'b0);
      send_must(8'hBB, 1'b0);
      send_must(8'hCC, 1'b0);
      do_flush();
      wait_done();
      chk("t2_nwr", 32'(wlog.size()), 32'd1);
      chk_wr(0, 32'h0, 32'h00CC_BBAA, 4'h7);

      // last byte together with flush
      wlog.delete();
      pulse_start();
      send_must(8'hAA, 1'b0);
      send_must(8'hBB, 1'b0);
      send_must(8'hCC, 1'b0);
      send_must(8'hDD, 1'b1);
      wait_done();
      chk("t3_nwr", 32'(wlog.size()), 32'd1);
      chk_wr(0, 32'h0, 32'hDDCC_BBAA, 4'hF);
      chk("t3_words", {29'b0, o_words}, 32'd1);

      // overflow: 20 bytes into a 16-byte RAM
      wlog.delete();
      pulse_start();
      nacc = 0;
      for (int i = 0; i < 20; i++) begin
         send_byte(8'(8'h30 + i), 1'b0, 30, acc);
         if (acc) nacc++;
      end
      chk("t4_accepted", 32'(nacc), 32'd16);
      chk("t4_nwr", 32'(wlog.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         chk_wr(i, 32'(4 * i), {8'(8'h33 + 4*i), 8'(8'h32 + 4*i), 8'(8'h31 + 4*i), 8'(8'h30 + 4*i)}, 4'hF);
      chk("t4_ovf", {31'b0, o_overflow}, 32'd1);
      chk("t4_ready", {31'b0, o_byte_ready}, 32'd0);
      chk("t4_done", {31'b0, o_done}, 32'd1);
      pulse_start();
      chk("t4_ovf_clr", {31'b0, o_overflow}, 32'd0);

      // stalled acknowledge: bus fields must hold
      stall_cfg = 5;
      tick();
      send_must(8'h11, 1'b0);
      send_must(8'h22, 1'b0);
      send_must(8'h33, 1'b0);
      send_must(8'h44, 1'b0);
      hold_dat = 32'h4433_2211;
      for (int k = 0; k < 4; k++) begin
         chk("t5_stb", {31'b0, o_wb_proc_stb}, 32'd1);
         chk("t5_ready", {31'b0, o_byte_ready}, 32'd0);
         chk("t5_dat", o_wb_proc_dat, hold_dat);
         chk("t5_sel", {28'b0, o_wb_proc_sel}, 32'hF);
         chk("t5_adr", o_wb_proc_adr, 32'h0);
         tick();
      end
      for (int k = 0; k < 10 && !o_byte_ready; k++) tick();
      chk("t5_resume", {31'b0, o_byte_ready}, 32'd1);

      // reset in the middle of a write
      stall_cfg = 20;
      for (int i = 0; i < 4; i++) send_must(8'(8'h50 + i), 1'b0);
      tick();
      tick();
      chk("t6_stb_before", {31'b0, o_wb_proc_stb}, 32'd1);
      rst_n = 1'b0;
      tick();
      chk("t6_stb_after", {31'b0, o_wb_proc_stb}, 32'd0);
      chk("t6_busy", {31'b0, o_busy}, 32'd0);
      rst_n = 1'b1;
      tick();

      // randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         start = ($urandom_range(0, 19) == 0);
         flush = ($urandom_range(0, 11) == 0);
         bval = ($urandom_range(0, 3) != 0);
         bdat = 8'($urandom);
         stall_cfg = $urandom_range(0, 3);
         rst_n = ($urandom_range(0, 399) != 0);
         tick();
      end
      start = 1'b0;
      flush = 1'b0;
      bval = 1'b0;
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
